// File: rtl/alu_nibble_sequencer_if.sv
// Request/response and ALU-drive bundle for alu_nibble_sequencer.
// The zero flag exists only when ALU_SEQ_ZFLAG_EN is defined.
interface alu_nibble_sequencer_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         start;
    logic         ready;
    logic [3:0]   op_sel;
    logic         op_m;
    logic         op_cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         carry;
    logic         equal;
    logic         done;
`ifdef ALU_SEQ_ZFLAG_EN
    logic         zero;
`endif
    logic [3:0]   alu_in1;
    logic [3:0]   alu_in2;
    logic [3:0]   alu_sel;
    logic         alu_m;
    logic         alu_cin;
    logic [3:0]   alu_out;
    logic         alu_cout;
    logic         alu_comparator;

    // Requester plus ALU instance side.
    modport master (
        output start, op_sel, op_m, op_cin, a, b,
        input  ready, result, carry, equal, done,
`ifdef ALU_SEQ_ZFLAG_EN
        input  zero,
`endif
        input  alu_in1, alu_in2, alu_sel, alu_m, alu_cin,
        output alu_out, alu_cout, alu_comparator
    );

    // Sequencer side.
    modport slave (
        input  start, op_sel, op_m, op_cin, a, b,
        output ready, result, carry, equal, done,
`ifdef ALU_SEQ_ZFLAG_EN
        output zero,
`endif
        output alu_in1, alu_in2, alu_sel, alu_m, alu_cin,
        input  alu_out, alu_cout, alu_comparator
    );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs one wide operation through a 4-bit ALU one nibble per cycle, LSB first,
// chaining carry and accumulating equality. Optional zero flag: ALU_SEQ_ZFLAG_EN.
module alu_nibble_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input logic                  clk,
    input logic                  rst,
    alu_nibble_sequencer_if.slave bus
);
    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [3:0]      sel_q, sel_d;
    logic            op_m_q, op_m_d;
    logic            op_cin_q, op_cin_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_run_q, carry_run_d;
    logic            eq_run_q, eq_run_d;
    logic [W-1:0]    result_q, result_d;
    logic            carry_q, carry_d;
    logic            equal_q, equal_d;
    logic            zero_q, zero_d;
    logic            last_c;

    assign last_c = (idx_q == LAST_IDX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (last_c)    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM-decoded outputs and ALU drive; the ALU bus is quiet outside RUN
    always_comb begin
        bus.ready   = (state_q == S_IDLE);
        bus.done    = (state_q == S_DONE);
        bus.alu_in1 = 4'b0;
        bus.alu_in2 = 4'b0;
        bus.alu_sel = 4'b0;
        bus.alu_m   = 1'b0;
        bus.alu_cin = 1'b0;
        if (state_q == S_RUN) begin
            bus.alu_in1 = 4'(a_q >> {idx_q, 2'b00});
            bus.alu_in2 = 4'(b_q >> {idx_q, 2'b00});
            bus.alu_sel = sel_q;
            bus.alu_m   = op_m_q;
            bus.alu_cin = (idx_q == '0) ? op_cin_q : (op_m_q ? 1'b0 : carry_run_q);
        end
    end

    // Operand latch, nibble write-back and flag accumulation
    always_comb begin
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        op_m_d      = op_m_q;
        op_cin_d    = op_cin_q;
        idx_d       = idx_q;
        carry_run_d = carry_run_q;
        eq_run_d    = eq_run_q;
        result_d    = result_q;
        carry_d     = carry_q;
        equal_d     = equal_q;
        zero_d      = zero_q;
        if (state_q == S_IDLE && bus.start) begin
            a_d         = bus.a;
            b_d         = bus.b;
            sel_d       = bus.op_sel;
            op_m_d      = bus.op_m;
            op_cin_d    = bus.op_cin;
            idx_d       = '0;
            carry_run_d = bus.op_cin;
            eq_run_d    = 1'b1;
        end else if (state_q == S_RUN) begin
            for (int unsigned i = 0; i < NIBBLES; i++) begin
                if (idx_q == IDXW'(i)) result_d[4*i +: 4] = bus.alu_out;
            end
            carry_run_d = bus.alu_cout;
            eq_run_d    = eq_run_q & bus.alu_comparator;
            // Visible flags change only with the final nibble.
            if (last_c) begin
                carry_d = bus.alu_cout;
                equal_d = eq_run_d;
                zero_d  = (result_d == '0);
            end else begin
                idx_d = idx_q + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            op_m_q      <= 1'b0;
            op_cin_q    <= 1'b0;
            idx_q       <= '0;
            carry_run_q <= 1'b0;
            eq_run_q    <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            equal_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            op_m_q      <= op_m_d;
            op_cin_q    <= op_cin_d;
            idx_q       <= idx_d;
            carry_run_q <= carry_run_d;
            eq_run_q    <= eq_run_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            equal_q     <= equal_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.result = result_q;
    assign bus.carry  = carry_q;
    assign bus.equal  = equal_q;
`ifdef ALU_SEQ_ZFLAG_EN
    assign bus.zero   = zero_q;
`else
    logic unused_zero;
    assign unused_zero = zero_q;
`endif
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for alu_nibble_sequencer (NIBBLES=4) with an adder ALU stub.
module tb_alu_nibble_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_nibble_sequencer_if #(.NIBBLES(4)) bus ();
    alu_nibble_sequencer #(.NIBBLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // ALU stub: nibble adder, equality comparator
    logic [4:0] alu_sum;
    assign alu_sum            = 5'(bus.alu_in1) + 5'(bus.alu_in2) + 5'(bus.alu_cin);
    assign bus.alu_out        = alu_sum[3:0];
    assign bus.alu_cout       = alu_sum[4];
    assign bus.alu_comparator = (bus.alu_in1 == bus.alu_in2);

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        m;
        logic        cin;
        logic [15:0] exp_res;
        logic        exp_c;
        logic        exp_e;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic for the chained mode, independent nibbles for logic mode
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic m, input logic cin,
                         output logic [15:0] res, output logic c, output logic e,
                         output logic [3:0] cseq);
        int ai = int'(a);
        int bi = int'(b);
        int ci = int'(cin);
        e    = (a == b);
        cseq = 4'b0;
        res  = 16'h0;
        c    = 1'b0;
        if (!m) begin
            int s = ai + bi + ci;
            res = 16'(s);
            c   = s[16];
            for (int k = 0; k < 4; k++) begin
                int mask = (1 << (4 * k)) - 1;
                int lo   = (ai & mask) + (bi & mask) + ci;
                cseq[k]  = (k == 0) ? cin : lo[4*k];
            end
        end else begin
            cseq[0] = cin;
            for (int k = 0; k < 4; k++) begin
                int s = ((ai >> (4 * k)) & 15) + ((bi >> (4 * k)) & 15) + ((k == 0) ? ci : 0);
                res = res | 16'((s & 15) << (4 * k));
                if (k == 3) c = s[4];
            end
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] sel,
                          input logic m, input logic cin,
                          output logic [15:0] res, output logic c, output logic e, output logic z,
                          output int lat, output logic [3:0] cseq, output logic [3:0] sel_seen,
                          output logic early_ok, output logic pulse_ok, output logic done_alu_zero);
        logic pc, pe;
        @(negedge clk);
        pc = bus.carry;
        pe = bus.equal;
        bus.a = a; bus.b = b; bus.op_sel = sel; bus.op_m = m; bus.op_cin = cin;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1; res = '0; c = 1'b0; e = 1'b0; z = 1'b0;
        cseq = '0; sel_seen = '0; early_ok = 1'b1; done_alu_zero = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (n > 1) @(negedge clk);
            if (bus.done) begin
                lat = n;
                res = bus.result; c = bus.carry; e = bus.equal;
`ifdef ALU_SEQ_ZFLAG_EN
                z = bus.zero;
`endif
                done_alu_zero = ({bus.alu_in1, bus.alu_in2, bus.alu_sel, bus.alu_m, bus.alu_cin} == 14'h0);
                break;
            end
            if (n <= 4) cseq[n-1] = bus.alu_cin;
            if (n == 1) sel_seen = bus.alu_sel;
            if (bus.carry !== pc || bus.equal !== pe || bus.ready) early_ok = 1'b0;
        end
        @(negedge clk);
        pulse_ok = !bus.done && bus.ready;
    endtask

    task automatic do_and_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] sel, input logic m, input logic cin,
                                input logic check_cseq);
        logic [15:0] res, er;
        logic c, e, z, ec, ee, eok, pok, dz;
        logic [3:0] cseq, ecs, ss;
        int lat;
        model(a, b, m, cin, er, ec, ee, ecs);
        run_op(a, b, sel, m, cin, res, c, e, z, lat, cseq, ss, eok, pok, dz);
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check({tag, "_result"}, 32'(res), 32'(er));
        check({tag, "_carry"}, 32'(c), 32'(ec));
        check({tag, "_equal"}, 32'(e), 32'(ee));
        if (check_cseq) begin
            check({tag, "_cin_seq"}, 32'(cseq), 32'(ecs));
            check({tag, "_sel"}, 32'(ss), 32'(sel));
            check({tag, "_flags_hidden"}, 32'(eok), 32'd1);
            check({tag, "_done_pulse"}, 32'(pok), 32'd1);
            check({tag, "_done_alu_idle"}, 32'(dz), 32'd1);
        end
`ifdef ALU_SEQ_ZFLAG_EN
        check({tag, "_zero"}, 32'(z), 32'(er == 16'h0));
`endif
    endtask

    vec_t vecs[7];

    initial begin
        logic [15:0] res;
        logic c, e, z, eok, pok, dz;
        logic [3:0] cseq, ss;
        int lat, dones, first_done, second_done;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'hFFF0, 1'b0, 1'b0};
        vecs[3] = '{16'hABCD, 16'hABCD, 1'b0, 1'b0, 16'h579A, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1};
        vecs[6] = '{16'h8888, 16'h8888, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b1};

        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.op_sel = '0; bus.op_m = 1'b0; bus.op_cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_ctrl", 32'({bus.ready, bus.done, bus.carry, bus.equal}), 32'h8);
            check("rst_result", 32'(bus.result), 32'h0);
            check("rst_alu", 32'({bus.alu_in1, bus.alu_in2, bus.alu_sel, bus.alu_m, bus.alu_cin}), 32'h0);
        end

        // Table of fixed vectors
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, 4'(i + 3), vecs[i].m, vecs[i].cin,
                   res, c, e, z, lat, cseq, ss, eok, pok, dz);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d_carry", i), 32'(c), 32'(vecs[i].exp_c));
            check($sformatf("vec%0d_equal", i), 32'(e), 32'(vecs[i].exp_e));
            check($sformatf("vec%0d_done_pulse", i), 32'(pok), 32'd1);
            if (i == 1) check("vec1_cin_seq", 32'(cseq), 32'b1110);
            if (i == 2) check("vec2_cin_seq", 32'(cseq), 32'b0000);
`ifdef ALU_SEQ_ZFLAG_EN
            check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].exp_res == 16'h0));
`endif
        end

        // start pulsed during RUN is ignored
        @(negedge clk);
        bus.a = 16'hABCD; bus.b = 16'hABCD; bus.op_m = 1'b0; bus.op_cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dones = 0;
        for (int n = 1; n <= 14; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 2) bus.start = 1'b1;
            if (n == 3) bus.start = 1'b0;
            if (bus.done) dones++;
        end
        check("run_start_ignored_dones", 32'(dones), 32'd1);
        check("run_start_ignored_ready", 32'(bus.ready), 32'd1);

        // start held high: back-to-back accepts, one op per 6 cycles
        @(negedge clk);
        bus.a = 16'h0102; bus.b = 16'h0304; bus.start = 1'b1;
        dones = 0; first_done = -1; second_done = -1;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (first_done < 0) first_done = n;
                else if (second_done < 0) second_done = n;
            end
        end
        bus.start = 1'b0;
        check("b2b_dones", 32'(dones), 32'd3);
        check("b2b_spacing", 32'(second_done - first_done), 32'd6);
        check("b2b_result", 32'(bus.result), 32'h0406);
        repeat (8) @(negedge clk);

        // rst during the second RUN cycle
        @(negedge clk);
        bus.a = 16'h5555; bus.b = 16'hAAAB; bus.op_m = 1'b0; bus.op_cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_ctrl", 32'({bus.ready, bus.done, bus.carry, bus.equal}), 32'h8);
        check("midrst_result", 32'(bus.result), 32'h0);
        check("midrst_alu", 32'({bus.alu_in1, bus.alu_in2, bus.alu_sel, bus.alu_m, bus.alu_cin}), 32'h0);
        rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        do_and_check("after_rst", 16'h5555, 16'hAAAB, 4'h2, 1'b0, 1'b0, 1'b1);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? ra : 16'($urandom);
            do_and_check($sformatf("rand%0d", i), ra, rb, 4'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
